// File: rtl/apb_modport.sv
// apb_modport: command-driven APB master with two 256-byte APB slave memories
//
// Ports:
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   transfer, READ_WRITE request a transfer; 1 = read, 0 = write
//   apb_write_paddr      write address, bit 8 selects the slave
//   apb_write_data       write data
//   apb_read_paddr       read address, bit 8 selects the slave
//   PSLVERR              slave error of the last completed transfer (registered)
//   apb_read_data_out    data of the last completed read (registered)
//
// Build option: define APB_WAIT_STATE_EN to make each slave insert one wait
// state (PREADY low for the first ACCESS cycle); otherwise PREADY is tied high.

module apb_mem_slave (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_psel,
    input  logic       i_penable,
    input  logic       i_pwrite,
    input  logic [7:0] i_paddr,
    input  logic [7:0] i_pwdata,
    output logic       o_pready,
    output logic [7:0] o_prdata,
    output logic       o_pslverr
);
    logic [7:0]   r_mem [0:255];
    logic [255:0] r_valid;
    logic         w_hit;

`ifdef APB_WAIT_STATE_EN
    logic r_waited;

    // High only during the second ACCESS cycle, so the first one stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_waited <= 1'b0;
        else          r_waited <= i_psel && i_penable && !r_waited;
    end

    assign o_pready = r_waited;
`else
    assign o_pready = 1'b1;
`endif

    assign w_hit = i_psel && i_penable && o_pready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)               r_valid <= '0;
        else if (w_hit && i_pwrite) r_valid[i_paddr] <= 1'b1;
    end

    // Contents survive reset; the cleared valid vector hides stale data.
    always_ff @(posedge i_clk) begin
        if (w_hit && i_pwrite) r_mem[i_paddr] <= i_pwdata;
    end

    assign o_prdata  = r_valid[i_paddr] ? r_mem[i_paddr] : 8'h00;
    assign o_pslverr = !i_pwrite && !r_valid[i_paddr];
endmodule

module apb_modport (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       transfer,
    input  logic       READ_WRITE,
    input  logic [8:0] apb_write_paddr,
    input  logic [7:0] apb_write_data,
    input  logic [8:0] apb_read_paddr,
    output logic       PSLVERR,
    output logic [7:0] apb_read_data_out
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t     r_state, w_next;
    logic       r_rw;
    logic [8:0] r_addr;
    logic [7:0] r_wdata;
    logic       w_psel0, w_psel1, w_penable, w_pwrite;
    logic       w_pready0, w_pready1, w_pready;
    logic [7:0] w_prdata0, w_prdata1, w_prdata;
    logic       w_pslverr0, w_pslverr1, w_pslverr;
    logic       w_done, w_capture;

    assign w_pready  = r_addr[8] ? w_pready1  : w_pready0;
    assign w_prdata  = r_addr[8] ? w_prdata1  : w_prdata0;
    assign w_pslverr = r_addr[8] ? w_pslverr1 : w_pslverr0;
    assign w_done    = (r_state == ACCESS) && w_pready;
    // A new command is latched exactly on the edge that enters SETUP.
    assign w_capture = transfer && ((r_state == IDLE) || w_done);

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)        w_next = transfer ? SETUP : IDLE;
        else if (r_state == SETUP)  w_next = ACCESS;
        else if (w_pready)          w_next = transfer ? SETUP : IDLE;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_capture) begin
            r_rw    <= READ_WRITE;
            r_addr  <= READ_WRITE ? apb_read_paddr : apb_write_paddr;
            r_wdata <= apb_write_data;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PSLVERR           <= 1'b0;
            apb_read_data_out <= 8'h00;
        end else if (w_done) begin
            PSLVERR <= w_pslverr;
            if (r_rw) apb_read_data_out <= w_prdata;
        end
    end

    assign w_psel0   = (r_state != IDLE) && !r_addr[8];
    assign w_psel1   = (r_state != IDLE) &&  r_addr[8];
    assign w_penable = (r_state == ACCESS);
    assign w_pwrite  = !r_rw;

    apb_mem_slave u_slave0 (
        .i_clk     (PCLK),
        .i_rst_n   (PRESETn),
        .i_psel    (w_psel0),
        .i_penable (w_penable),
        .i_pwrite  (w_pwrite),
        .i_paddr   (r_addr[7:0]),
        .i_pwdata  (r_wdata),
        .o_pready  (w_pready0),
        .o_prdata  (w_prdata0),
        .o_pslverr (w_pslverr0)
    );

    apb_mem_slave u_slave1 (
        .i_clk     (PCLK),
        .i_rst_n   (PRESETn),
        .i_psel    (w_psel1),
        .i_penable (w_penable),
        .i_pwrite  (w_pwrite),
        .i_paddr   (r_addr[7:0]),
        .i_pwdata  (r_wdata),
        .o_pready  (w_pready1),
        .o_prdata  (w_prdata1),
        .o_pslverr (w_pslverr1)
    );
endmodule

// File: tb/tb_apb_modport.sv
// tb_apb_modport: directed self-checking bench for apb_modport
module tb_apb_modport;
`ifdef APB_WAIT_STATE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       transfer = 1'b0;
    logic       READ_WRITE = 1'b0;
    logic [8:0] apb_write_paddr = '0;
    logic [7:0] apb_write_data = '0;
    logic [8:0] apb_read_paddr = '0;
    logic       PSLVERR;
    logic [7:0] apb_read_data_out;

    int         n_run = 0;
    int         n_fail = 0;
    logic [7:0] exp_d = 8'h00;
    logic       exp_e = 1'b0;

    apb_modport dut (
        .PCLK              (PCLK),
        .PRESETn           (PRESETn),
        .transfer          (transfer),
        .READ_WRITE        (READ_WRITE),
        .apb_write_paddr   (apb_write_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_paddr    (apb_read_paddr),
        .PSLVERR           (PSLVERR),
        .apb_read_data_out (apb_read_data_out)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [7:0] d, input logic e);
        n_run += 2;
        assert (apb_read_data_out === d) else begin
            n_fail++;
            $error("FAIL %s data observed=%h expected=%h", tag, apb_read_data_out, d);
        end
        assert (PSLVERR === e) else begin
            n_fail++;
            $error("FAIL %s pslverr observed=%b expected=%b", tag, PSLVERR, e);
        end
        exp_d = d;
        exp_e = e;
    endtask

    // One isolated transfer; inputs are scrambled after the SETUP edge to
    // prove they are latched, and the task returns just after completion.
    task automatic xfer(input logic rw, input logic [8:0] a, input logic [7:0] d);
        @(negedge PCLK);
        transfer = 1'b1;
        READ_WRITE = rw;
        apb_write_paddr = a;
        apb_read_paddr = a;
        apb_write_data = d;
        @(posedge PCLK);
        @(negedge PCLK);
        transfer = 1'b0;
        READ_WRITE = ~rw;
        apb_write_paddr = a ^ 9'h1FF;
        apb_read_paddr = a ^ 9'h1FF;
        apb_write_data = ~d;
        @(posedge PCLK);
`ifdef APB_WAIT_STATE_EN
        @(posedge PCLK);
        #1;
        chk("no_change_at_n2", exp_d, exp_e);
`endif
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge PCLK);
        #1;
        chk("reset_state", 8'h00, 1'b0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        xfer(1'b1, 9'h1FF, 8'h00);
        chk("unwritten_1ff", 8'h00, 1'b1);
        xfer(1'b0, 9'h010, 8'hA5);
        chk("write_010_a5", 8'h00, 1'b0);
        xfer(1'b1, 9'h010, 8'h00);
        chk("read_010_a5", 8'hA5, 1'b0);

        xfer(1'b0, 9'h110, 8'h3C);
        chk("write_110_3c", 8'hA5, 1'b0);
        xfer(1'b0, 9'h010, 8'hC3);
        chk("write_010_c3", 8'hA5, 1'b0);
        xfer(1'b1, 9'h110, 8'h00);
        chk("read_110_3c", 8'h3C, 1'b0);
        xfer(1'b1, 9'h0AA, 8'h00);
        chk("unwritten_0aa", 8'h00, 1'b1);
        xfer(1'b1, 9'h010, 8'h00);
        chk("read_010_c3", 8'hC3, 1'b0);

        // Reset in the middle of a write to 9'h005.
        @(negedge PCLK);
        transfer = 1'b1;
        READ_WRITE = 1'b0;
        apb_write_paddr = 9'h005;
        apb_write_data = 8'h77;
        @(posedge PCLK);
        @(negedge PCLK);
        transfer = 1'b0;
        @(posedge PCLK);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("mid_xfer_reset", 8'h00, 1'b0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        chk("idle_after_reset", 8'h00, 1'b0);
        xfer(1'b1, 9'h005, 8'h00);
        chk("aborted_write_005", 8'h00, 1'b1);
        xfer(1'b1, 9'h010, 8'h00);
        chk("valid_cleared_010", 8'h00, 1'b1);

        // Back-to-back write then read of 9'h020 with transfer held high.
        @(negedge PCLK);
        transfer = 1'b1;
        READ_WRITE = 1'b0;
        apb_write_paddr = 9'h020;
        apb_write_data = 8'h11;
        @(posedge PCLK);
        @(negedge PCLK);
        READ_WRITE = 1'b1;
        apb_read_paddr = 9'h020;
        apb_write_paddr = 9'h0FF;
        apb_write_data = 8'hEE;
        repeat (LAT) @(posedge PCLK);
        #1;
        chk("b2b_write_020", 8'h00, 1'b0);
        @(negedge PCLK);
        transfer = 1'b0;
        repeat (LAT - 1) @(posedge PCLK);
        #1;
        chk("b2b_read_not_early", 8'h00, 1'b0);
        @(posedge PCLK);
        #1;
        chk("b2b_read_020", 8'h11, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_modport.md
# apb_modport

APB subsystem with a simple command port, an APB master and two 256-byte APB slave memories. A testbench or host issues single read or write commands. The block runs the standard IDLE/SETUP/ACCESS protocol internally and returns read data plus an error flag. Address bit 8 selects the slave.

## Interface
- No parameters; widths are fixed.
- PCLK  in  1  system clock; all state changes on rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- transfer  in  1  request a transfer; sampled each PCLK rising edge.
- READ_WRITE  in  1  1 = read, 0 = write; sampled with transfer.
- apb_write_paddr  in  9  write address; bit 8 selects the slave (0 = slave 0, 1 = slave 1); bits 7:0 select the byte.
- apb_write_data  in  8  write data.
- apb_read_paddr  in  9  read address; same decoding as apb_write_paddr.
- PSLVERR  out  1  slave error for the last completed transfer.
- apb_read_data_out  out  8  data returned by the last completed read.

## Operation
- Master FSM states:
  - IDLE (reset state).
  - IDLE→SETUP when transfer=1.
  - SETUP→ACCESS unconditionally.
  - ACCESS, PREADY=1, transfer=1 → SETUP (back-to-back transfer).
  - ACCESS, PREADY=1, transfer=0 → IDLE.
  - ACCESS, PREADY=0 → stay in ACCESS.
- Command capture:
  - READ_WRITE, the selected address and apb_write_data are latched on the edge that enters SETUP.
  - Input changes during SETUP or ACCESS are ignored.
- Internal APB signals:
  - PSEL0 is driven when latched addr[8]=0; PSEL1 when addr[8]=1.
  - PENABLE=1 only in ACCESS.
  - PWRITE = !READ_WRITE.
  - PADDR = latched addr[7:0].
- Each slave holds a 256×8 memory plus a 256-bit valid vector.
- Write completion: memory[addr] ← data and valid[addr] ← 1. A write always has PSLVERR=0.
- Read completion:
  - valid[addr]=1: apb_read_data_out ← memory[addr], PSLVERR ← 0.
  - valid[addr]=0 (location never written since reset): apb_read_data_out ← 8'h00, PSLVERR ← 1.
- Output hold rules:
  - apb_read_data_out changes only when a read completes; writes leave it unchanged.
  - PSLVERR is updated at every transfer completion and holds between completions.
- Reset (PRESETn=0, at any time, including mid-transfer):
  - FSM → IDLE; PSLVERR=0; apb_read_data_out=8'h00.
  - All valid bits cleared; memory contents need not be cleared.
  - An in-flight write is aborted and leaves no memory effect.

## Timing
- No wait states: transfer=1 sampled at edge N enters SETUP. ACCESS follows at edge N+1. The transfer completes at edge N+2, and both outputs are valid after edge N+2.
- If transfer is held high, a new transfer completes every 2 cycles.
- A write followed immediately by a read of the same address returns the new data.
- Both outputs are registered; there is no combinational path from the inputs to the outputs.

## Configuration
- APB_WAIT_STATE_EN defined: each slave drives PREADY=0 for the first ACCESS cycle and 1 for the second. Completion moves to edge N+3; back-to-back throughput is one transfer per 3 cycles.
- APB_WAIT_STATE_EN undefined: PREADY is tied to 1 and the timing is as above.

## Test plan
- Reset check: assert PRESETn=0 mid-transfer → PSLVERR=0, apb_read_data_out=8'h00, FSM returns to IDLE. Then read 9'h005 → PSLVERR=1, data 8'h00.
- Write/read slave 0: write 8'hA5 to 9'h010, then read 9'h010 → apb_read_data_out=8'hA5 at edge N+2 of the read, PSLVERR=0.
- Slave select: write 8'h3C to 9'h110 and 8'hC3 to 9'h010. Read 9'h110 → 8'h3C; read 9'h010 → 8'hC3.
- Unwritten read: after reset, read 9'h1FF → PSLVERR=1, data 8'h00. A following valid read clears PSLVERR to 0.
- Back-to-back: hold transfer=1 across write 9'h020←8'h11 then read 9'h020 → second completion 2 cycles after the first, data 8'h11.
- With APB_WAIT_STATE_EN defined: a single read completes at edge N+3. Check that no output changes at edge N+2.
